// File: rtl/grayscale_pkg.sv
// Shared constants and pixel types for the BT.601 grayscale converter.
// Weights are 8-bit fixed point and sum to 256, so the luma never exceeds full scale.
package grayscale_pkg;

  localparam int C_WEIGHT_R  = 77;
  localparam int C_WEIGHT_G  = 150;
  localparam int C_WEIGHT_B  = 29;
  localparam int C_FRAC_BITS = 8;
  localparam int C_ROUND     = 128;
  localparam int C_NUM_CH    = 3;
  localparam int C_CW        = 8;

  typedef logic [C_CW-1:0] channel_t;

  typedef struct packed {
    channel_t r;
    channel_t g;
    channel_t b;
  } rgb_t;

  // Channel index follows packed bit order: 0 = B (LSBs), 2 = R (MSBs).
  function automatic int weight_of(input int ch);
    case (ch)
      0:       return C_WEIGHT_B;
      1:       return C_WEIGHT_G;
      default: return C_WEIGHT_R;
    endcase
  endfunction

endpackage

// File: rtl/grayscale_weight_mul.sv
// Registered unsigned channel x constant-weight multiplier (one luma term).
module grayscale_weight_mul
  import grayscale_pkg::*;
#(
  parameter int CW     = 8,
  parameter int WEIGHT = 77
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [CW-1:0]          din,
  output logic [CW+C_FRAC_BITS-1:0] prod
);

  localparam int PW = CW + C_FRAC_BITS;
  localparam logic [PW-1:0] C_W = PW'(WEIGHT);

  logic [PW-1:0] din_ext;
  assign din_ext = {{C_FRAC_BITS{1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  prod <= '0;
    else if (en) prod <= din_ext * C_W;
  end

endmodule

// File: rtl/grayscale_core.sv
// Two-stage RGB -> BT.601 luma converter; output is {Y, Y, Y} in the input pixel format.
// Stage 1: three weighted products. Stage 2: rounded sum, >> 8, replicated.
module grayscale_core
  import grayscale_pkg::*;
#(
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL
);

  localparam int CW = P_PIXEL_DEPTH / C_NUM_CH;
  localparam int PW = CW + C_FRAC_BITS;
  localparam int SW = PW + 1;

  logic [C_NUM_CH-1:0][CW-1:0] ch;
  logic [C_NUM_CH-1:0][PW-1:0] prod;
  logic [SW-1:0]               sum;
  logic [CW-1:0]               y;
  logic                        unused_bits;

  assign ch = I_PIXEL;

  generate
    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
      grayscale_weight_mul #(
        .CW     (CW),
        .WEIGHT (weight_of(i))
      ) u_mul (
        .clk   (I_CLK),
        .rst_n (I_RESET),
        .en    (I_ENABLE),
        .din   (ch[i]),
        .prod  (prod[i])
      );
    end
  endgenerate

  // Weights sum to 256, so the top sum bit stays clear and Y never wraps.
  assign sum = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) + SW'(C_ROUND);
  assign y   = sum[C_FRAC_BITS +: CW];
  assign unused_bits = ^{sum[SW-1], sum[C_FRAC_BITS-1:0]};

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET)      O_PIXEL <= '0;
    else if (I_ENABLE) O_PIXEL <= {C_NUM_CH{y}};
  end

endmodule

// File: tb/tb_grayscale_core.sv
// Self-checking bench: fixed vectors, stall and async-reset sequences, random stream vs luma model.
module tb_grayscale_core;
  import grayscale_pkg::*;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] exp;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [23:0] pix   = '0;
  logic [23:0] out;

  int checks = 0;
  int errors = 0;

  // Model: output after an enabled edge is the luma of the pixel sampled on the prior enabled edge.
  logic [23:0] m_last = '0;
  logic [23:0] m_out  = '0;

  always #5 clk = ~clk;

  grayscale_core #(.P_PIXEL_DEPTH(24)) dut (
    .I_CLK    (clk),
    .I_RESET  (rst_n),
    .I_ENABLE (en),
    .I_PIXEL  (pix),
    .O_PIXEL  (out)
  );

  function automatic logic [23:0] gray(input logic [23:0] p);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (r * 77 + g * 150 + b * 29 + 128) / 256;
    if (y > 255) y = 255;
    return {3{y[7:0]}};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && en) begin
      m_out  = gray(m_last);
      m_last = pix;
    end
    #1;
    check("model", out, m_out);
  endtask

  task automatic model_reset();
    m_last = '0;
    m_out  = '0;
  endtask

  vec_t vec[7];

  initial begin
    vec[0] = '{24'hFF7F00, 24'h979797};
    vec[1] = '{24'hFFFFFF, 24'hFFFFFF};
    vec[2] = '{24'h000000, 24'h000000};
    vec[3] = '{24'hFF0000, 24'h4D4D4D};
    vec[4] = '{24'h00FF00, 24'h959595};
    vec[5] = '{24'h0000FF, 24'h1D1D1D};
    vec[6] = '{24'h808080, 24'h808080};

    // Reset hold
    #1 rst_n = 1'b0;
    en = 1'b1;
    pix = '0;
    model_reset();
    #1 check("rst_during", out, 24'h000000);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_after", out, 24'h000000);

    // Back-to-back table stream, one-edge lag after the sampling edge
    for (int i = 0; i < 7; i++) begin
      pix = vec[i].pix;
      tick();
      if (i > 0) check("vec", out, vec[i-1].exp);
    end
    pix = '0;
    tick();
    check("vec_last", out, vec[6].exp);

    // Enable stall
    pix = 24'hFF7F00;
    tick();
    check("stall_pre", out, 24'h000000);
    en  = 1'b0;
    pix = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", out, 24'h000000);
    end
    en = 1'b1;
    tick();
    check("stall_release", out, 24'h979797);
    pix = '0;
    tick();
    check("stall_next", out, 24'hFFFFFF);

    // Mid-stream async reset between edges
    pix = 24'hFFFFFF;
    tick();
    tick();
    check("full_pipe", out, 24'hFFFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", out, 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    pix = 24'h00FF00;
    tick();
    check("post_rst_first", out, 24'h000000);
    pix = '0;
    tick();
    check("post_rst_fresh", out, 24'h959595);

    // Random stream with random stalls and occasional async reset pulses
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      pix = 24'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 check("rand_rst", out, 24'h000000);
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grayscale_core.md
Name: grayscale_core

Overview:
- Pipelined RGB-to-grayscale converter for the edge-detection datapath.
- Sits between pixel ingest and the edge-detection (Sobel) stages.
- Each clock-enabled cycle it accepts one packed RGB pixel and computes a fixed-point BT.601 luma value.
- Emits the luma replicated into all three channels, so the output keeps the input pixel format.

Parameters:
- P_PIXEL_DEPTH, 24, packed pixel width in bits. Must be a multiple of 3; channel width CW = P_PIXEL_DEPTH/3 (8 at default).

Ports:
- I_CLK  input  1  sole clock; all state updates on its rising edge.
- I_RESET  input  1  asynchronous, active-low reset.
- I_ENABLE  input  1  pipeline clock-enable; high = advance, low = hold all registers.
- I_PIXEL  input  P_PIXEL_DEPTH  packed RGB: R = [3CW-1:2CW], G = [2CW-1:CW], B = [CW-1:0].
- O_PIXEL  output  P_PIXEL_DEPTH  registered grayscale pixel {Y, Y, Y}.

Behaviour:
- Luma: Y = (77*R + 150*G + 29*B + 128) >> 8. Weights sum to 256, giving 8 fractional bits with round-half-up.
- Arithmetic widths:
  - Each product is CW+8 bits, unsigned.
  - The sum is CW+9 bits, so no intermediate overflow.
  - Result is the top CW bits after the shift.
  - Maximum input (all channels 255) gives exactly 255; no saturation logic is needed, but the result must never wrap.
- Pipeline, 2 register stages:
  - Stage 1 registers the three weighted products.
  - Stage 2 registers the rounded sum and shift, replicated to {Y, Y, Y}, which drives O_PIXEL.
  - Latency is 2 enabled rising edges from I_PIXEL sample to O_PIXEL update. Throughput is 1 pixel per enabled cycle.
- Enable:
  - I_ENABLE low freezes both stages; O_PIXEL holds its value.
  - Gaps in I_ENABLE stretch latency in enabled cycles only; disabled cycles do not count toward the 2-edge latency.
  - No data is lost or duplicated.
- Reset:
  - I_RESET low immediately (asynchronously) clears both stages; O_PIXEL = 0.
  - Reset overrides enable.
  - Reset asserted mid-stream discards in-flight pixels.
  - After release, the first valid output appears 2 enabled edges after the first sampled pixel. Until then O_PIXEL shows zeros or reset-cleared pipeline contents (luma of 0 = 0).
- No handshake, no valid flag; the upstream block owns framing.
- O_PIXEL is purely registered: no combinational path from inputs to output.

Decomposition:
- Shared package grayscale_pkg:
  - Coefficient constants: C_WEIGHT_R = 77, C_WEIGHT_G = 150, C_WEIGHT_B = 29.
  - C_FRAC_BITS = 8, C_ROUND = 128.
  - Typedef for a CW-bit channel and a packed RGB struct {r, g, b}.
- One natural sub-module: grayscale_weight_mul.
  - Registered unsigned channel × constant-weight multiplier with enable and async active-low reset.
  - Instantiated three times to form stage 1.

Test Plan:
- Reset hold: I_RESET low for 1 cycle with I_PIXEL = 0 -> O_PIXEL = 0x000000 during reset and after release.
- Orange: I_PIXEL = 0xFF7F00, enable high -> O_PIXEL = 0x979797 (Y = 151) exactly 2 edges later.
- Extremes: 0xFFFFFF -> 0xFFFFFF. 0x000000 -> 0x000000. Pure 0xFF0000 -> 0x4D4D4D. 0x00FF00 -> 0x959595. 0x0000FF -> 0x1D1D1D.
- Back-to-back stream: 0xFF0000, 0x00FF00, 0x0000FF on consecutive edges -> 0x4D4D4D, 0x959595, 0x1D1D1D on consecutive edges, with 2-cycle lag.
- Enable stall: feed 0xFF7F00, drop I_ENABLE for 3 cycles, change I_PIXEL to 0xFFFFFF while disabled -> O_PIXEL holds and no new sample is taken. After re-enable, 0x979797 appears on the 2nd enabled edge counted from the edge that sampled 0xFF7F00.
- Mid-stream async reset: assert I_RESET between clock edges while the pipeline is full -> O_PIXEL = 0 immediately, without waiting for a clock edge. After release, only freshly sampled pixels emerge.
